// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and the
// adder-result byte packing used by the TX path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  // Adder result occupies the low five bits; the upper three are always zero.
  function automatic logic [7:0] pack_result(input logic [3:0] sum, input logic cout);
    return {3'b000, cout, sum};
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick_o pulses for one cycle every CLKS_PER_BIT cycles;
// clear_i restarts the period from zero.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o,
  output logic tick_next_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Tells a registered consumer that tick_o will be high next cycle.
  assign tick_next_o = (cnt_d == LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adder_result_uart_tx.sv
// Serialises one adder result (sum + carry-out) as an 8N1 UART frame.
// Result handshake: a transfer happens on a rising edge where valid_i and ready_o are both 1; ready_o is high only in IDLE.
module adder_result_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] sum_i,
  input  logic       cout_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  tx_state_t  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       xfer;
  logic       tick;
  logic       tick_next;
  logic       baud_clear;

  assign ready_o = (state_q == IDLE);
  assign xfer    = valid_i && ready_o;

  // The bit timer is held at zero while idle and restarts on every state change.
  assign baud_clear = (state_q == IDLE) || (state_d != state_q);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (baud_clear),
    .tick_o     (tick),
    .tick_next_o(tick_next)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = IDLE_LEVEL;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = START;
          shift_d = pack_result(sum_i, cout_i);
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the flops hold the line
    // level for the coming cycle.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[bit_idx_d];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && tick_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_adder_result_uart_tx.sv
// Directed bench for adder_result_uart_tx with CLKS_PER_BIT=4: frames are
// captured cycle by cycle and checked against bytes queued at transfer time.
module tb_adder_result_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sum;
  logic       cout;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int d1, d2, dummy;
  logic [7:0] aborted;

  adder_result_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sum_i  (sum),
    .cout_i (cout),
    .valid_i(valid),
    .ready_o(ready),
    .tx_o   (tx),
    .busy_o (busy),
    .done_o (done)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a result and queue its expected byte; returns just after the transfer edge.
  task automatic drive_result(input logic [3:0] s, input logic c);
    sum   = s;
    cout  = c;
    valid = 1'b1;
    exp_q.push_back({3'b000, c, s});
    step();
  endtask

  // Called right after a transfer edge: samples 40 frame cycles plus the
  // following idle cycle and scores the frame against the queue head.
  task automatic capture_frame(input string tag, input bit jitter, output int done_at);
    logic [FRAME-1:0] tx_v;
    logic [FRAME-1:0] exp_v;
    logic [7:0] exp_b;
    logic [7:0] dec;
    int ready_bad, busy_bad, done_cnt, done_k;
    ready_bad = 0; busy_bad = 0; done_cnt = 0; done_k = 0; done_at = -1;
    for (int k = 1; k <= FRAME; k++) begin
      tx_v[k-1] = tx;
      if (ready !== 1'b0) ready_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_k  = k;
        done_at = cyc;
      end
      if (jitter) begin
        sum   = 4'($urandom_range(0, 15));
        cout  = 1'($urandom_range(0, 1));
        valid = (k < FRAME) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      step();
    end
    check({tag, "_queued"}, 64'(exp_q.size() > 0), 64'd1);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    for (int k = 0; k < FRAME; k++) begin
      if (k / CPB == 0) exp_v[k] = 1'b0;
      else if (k / CPB == 9) exp_v[k] = 1'b1;
      else exp_v[k] = exp_b[k / CPB - 1];
    end
    for (int i = 0; i < 8; i++) dec[i] = tx_v[CPB * (i + 1) + 1];
    check({tag, "_tx_seq"}, 64'(tx_v), 64'(exp_v));
    check({tag, "_byte"}, 64'(dec), 64'(exp_b));
    check({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
    check({tag, "_busy_high"}, 64'(busy_bad), 64'd0);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_cycle"}, 64'(done_k), 64'(FRAME));
    check({tag, "_idle_tx"}, 64'(tx), 64'd1);
    check({tag, "_idle_ready"}, 64'(ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b0;
    sum   = 4'h3;
    cout  = 1'b1;
    valid = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_tx", 64'(tx), 64'd1);

    drive_result(4'hA, 1'b1);
    valid = 1'b0;
    capture_frame("single_1a", 1'b0, dummy);

    drive_result(4'h0, 1'b0);
    valid = 1'b0;
    capture_frame("min_00", 1'b0, dummy);

    drive_result(4'hF, 1'b1);
    valid = 1'b0;
    capture_frame("max_1f", 1'b0, dummy);

    // Back-to-back: valid stays high, second result presented while busy.
    drive_result(4'h5, 1'b0);
    sum  = 4'h3;
    cout = 1'b1;
    exp_q.push_back(8'h13);
    capture_frame("b2b_05", 1'b0, d1);
    step();
    valid = 1'b0;
    capture_frame("b2b_13", 1'b0, d2);
    check("b2b_done_gap", 64'(d2 - d1), 64'(FRAME + 1));

    drive_result(4'hC, 1'b0);
    capture_frame("jitter_0c", 1'b1, dummy);
    valid = 1'b0;
    step();
    check("jitter_no_xfer", 64'(busy), 64'd0);

    // Abort during data bit 3 (frame cycles 17..20).
    drive_result(4'h5, 1'b1);
    valid = 1'b0;
    for (int k = 1; k < 18; k++) step();
    check("abort_bit3", 64'(tx), 64'd0);
    rst_n = 1'b0;
    step();
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    step();
    check("abort_done_hold", 64'(done), 64'd0);
    aborted = exp_q.pop_front();
    check("abort_byte_was_15", 64'(aborted), 64'h15);
    rst_n = 1'b1;
    step();
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_idle_tx", 64'(tx), 64'd1);

    drive_result(4'h7, 1'b0);
    valid = 1'b0;
    capture_frame("after_abort_07", 1'b0, dummy);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
